// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per operation.
// Zero divisor bypasses the iteration and reports all-ones quotient with the dividend as remainder.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH:0]   part_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH:0]   part_d;
    logic [WIDTH-1:0] work_d;

    // Compare/subtract is WIDTH+1 bits so the bit shifted out of the partial is never lost.
    always_comb begin
        shifted = (part_q << 1) | {{WIDTH{1'b0}}, work_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvsr_q});
        part_d  = ge ? (shifted - {1'b0, dvsr_q}) : shifted;
        work_d  = {work_q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            part_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q <= dividend;
                        dvsr_q <= divisor;
                        part_q <= '0;
                        cnt_q  <= CW'(WIDTH - 1);
                        dbz_q  <= (divisor == '0);
                        if (divisor == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    part_q <= part_d;
                    work_q <= work_d;
                    // Last step publishes the freshly computed bits, not the stale registers.
                    if (cnt_q == '0) begin
                        quot_q  <= work_d;
                        rem_q   <= part_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
